// File: rtl/hs_pkg.sv
// Shared definitions for the hs_buffer handshake FIFO.
// Contents: default payload width / depth, and the occupancy FSM state type.
package hs_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_DEPTH  = 4;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } state_t;

endpackage

// File: rtl/hs_ram.sv
// Storage array for hs_buffer: DEPTH x DATA_W, one synchronous write port,
// asynchronous read port. Contents are never reset.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module hs_ram #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Single write port
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hs_buffer.sv
// Valid/ready elastic FIFO buffer with EMPTY/PARTIAL/FULL occupancy FSM.
// Optional macro HS_BUFFER_BYPASS_EN: when EMPTY and s_valid && m_ready, the
// beat is forwarded combinationally from s_data to m_data without storage.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-high reset
//   s_data  - upstream payload
//   s_valid - upstream payload valid
//   s_ready - buffer can accept a beat (from state register only)
//   m_data  - downstream payload (head entry; 0 while empty)
//   m_valid - downstream payload valid
//   m_ready - downstream accepts a beat
//   count   - current occupancy
module hs_buffer
   import hs_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_W-1:0]        s_data,
   input  logic                     s_valid,
   output logic                     s_ready,
   output logic [DATA_W-1:0]        m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   state_t             state, state_nx;
   logic [PTR_W-1:0]   wr_ptr, wr_ptr_nx;
   logic [PTR_W-1:0]   rd_ptr, rd_ptr_nx;
   logic [CNT_W-1:0]   count_nx;
   logic               wr_en;
   logic               rd_en;
   logic               bypass;
   logic [DATA_W-1:0]  head;

   hs_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (s_data),
      .raddr (rd_ptr),
      .rdata (head)
   );

   // State, pointer and occupancy registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= EMPTY;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         state  <= state_nx;
         wr_ptr <= wr_ptr_nx;
         rd_ptr <= rd_ptr_nx;
         count  <= count_nx;
      end
   end

   // Next-state, pointer and occupancy logic
   always_comb begin
      state_nx  = state;
      wr_ptr_nx = wr_ptr;
      rd_ptr_nx = rd_ptr;
      count_nx  = count;
      bypass    = 1'b0;
`ifdef HS_BUFFER_BYPASS_EN
      bypass    = (state == EMPTY) && s_valid && m_ready;
`endif
      // FULL blocks writes even when a read frees a slot this cycle
      wr_en = s_valid && (state != FULL) && !bypass;
      rd_en = m_ready && (state != EMPTY);

      // DEPTH is a power of two, so natural overflow wraps the pointers
      if (wr_en) wr_ptr_nx = wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr_nx = rd_ptr + PTR_W'(1);

      case (state)
         EMPTY: begin
            if (wr_en) begin
               state_nx = PARTIAL;
               count_nx = CNT_W'(1);
            end
         end
         PARTIAL: begin
            if (wr_en && !rd_en) begin
               count_nx = count + CNT_W'(1);
               if (count_nx == CNT_W'(DEPTH)) state_nx = FULL;
            end else if (rd_en && !wr_en) begin
               count_nx = count - CNT_W'(1);
               if (count_nx == '0) state_nx = EMPTY;
            end
         end
         FULL: begin
            if (rd_en) begin
               state_nx = PARTIAL;
               count_nx = count - CNT_W'(1);
            end
         end
         default: state_nx = EMPTY;
      endcase
   end

   assign s_ready = (state != FULL);

`ifdef HS_BUFFER_BYPASS_EN
   assign m_valid = (state != EMPTY) || bypass;
   assign m_data  = bypass ? s_data : ((state == EMPTY) ? '0 : head);
`else
   assign m_valid = (state != EMPTY);
   assign m_data  = (state == EMPTY) ? '0 : head;
`endif

endmodule
